instr_register_alu: RTL

INSTR_REGISTER_ALU -- requirements
Module: instr_register_alu

---
 rtl/instr_register_alu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/instr_register_alu.sv
// Instruction register file with a two-stage write pipeline (capture, then ALU + commit)
// and a one-cycle registered read port with write-first bypass from the commit stage.
`timescale 1ns/1ps
module instr_register_alu #(
   parameter int DEPTH = 32,
   parameter int OP_W  = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int RES_W = 2 * OP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [AW-1:0]     write_pointer,
   input  logic [2:0]        opcode,
   input  logic [OP_W-1:0]   operand_a,
   input  logic [OP_W-1:0]   operand_b,
   input  logic              clear_all,
   input  logic              read_en,
   input  logic [AW-1:0]     read_pointer,
   output logic [2:0]        rd_opc,
   output logic [OP_W-1:0]   rd_op_a,
   output logic [OP_W-1:0]   rd_op_b,
   output logic [RES_W-1:0]  rd_rez,
   output logic              rd_valid,
   output logic              rd_entry_valid,
   output logic              rd_div_zero,
   output logic [AW:0]       occupancy
);

   typedef struct packed {
      logic [2:0]       opc;
      logic [OP_W-1:0]  op_a;
      logic [OP_W-1:0]  op_b;
      logic [RES_W-1:0] rez;
      logic             div_zero;
   } entry_t;

   logic             s1_valid;
   logic [AW-1:0]    s1_ptr;
   logic [2:0]       s1_opc;
   logic [OP_W-1:0]  s1_a;
   logic [OP_W-1:0]  s1_b;

   entry_t           mem [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [AW:0]      occ_d;

   logic signed [RES_W-1:0] a_ext;
   logic signed [RES_W-1:0] b_ext;
   logic signed [RES_W-1:0] div_b;
   entry_t           commit;
   entry_t           rd_src;
   logic             rd_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_ptr   <= '0;
         s1_opc   <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         s1_valid <= load_en;
         if (load_en) begin
            s1_ptr <= write_pointer;
            s1_opc <= opcode;
            s1_a   <= operand_a;
            s1_b   <= operand_b;
         end
      end
   end

   // Operand a is signed, b unsigned; widening both to RES_W makes every result exact.
   always_comb begin
      a_ext = {{OP_W{s1_a[OP_W-1]}}, s1_a};
      b_ext = {{OP_W{1'b0}}, s1_b};
      div_b = (s1_b == '0) ? {{(RES_W-1){1'b0}}, 1'b1} : b_ext;
      commit.opc      = s1_opc;
      commit.op_a     = s1_a;
      commit.op_b     = s1_b;
      commit.rez      = '0;
      commit.div_zero = 1'b0;
      case (s1_opc)
         3'd1: commit.rez = a_ext;
         3'd2: commit.rez = b_ext;
         3'd3: commit.rez = a_ext + b_ext;
         3'd4: commit.rez = a_ext - b_ext;
         3'd5: commit.rez = a_ext * b_ext;
         3'd6: begin
            if (s1_b == '0) commit.div_zero = 1'b1;
            else            commit.rez = a_ext / div_b;
         end
         3'd7: begin
            if (s1_b == '0) commit.div_zero = 1'b1;
            else            commit.rez = a_ext % div_b;
         end
         default: commit.rez = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (s1_valid) mem[s1_ptr] <= commit;
   end

   // A commit on the clearing edge survives the clear.
   always_comb begin
      valid_d = valid_q;
      occ_d   = occupancy;
      if (clear_all) begin
         valid_d = '0;
         occ_d   = '0;
      end
      if (s1_valid) begin
         if (!valid_d[s1_ptr]) occ_d = occ_d + (AW+1)'(1);
         valid_d[s1_ptr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= '0;
         occupancy <= '0;
      end else begin
         valid_q   <= valid_d;
         occupancy <= occ_d;
      end
   end

   always_comb begin
      rd_src = '0;
      rd_hit = 1'b0;
      if (s1_valid && s1_ptr == read_pointer) begin
         rd_src = commit;
         rd_hit = 1'b1;
      end else if (valid_q[read_pointer]) begin
         rd_src = mem[read_pointer];
         rd_hit = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid       <= 1'b0;
         rd_entry_valid <= 1'b0;
         rd_div_zero    <= 1'b0;
         rd_opc         <= '0;
         rd_op_a        <= '0;
         rd_op_b        <= '0;
         rd_rez         <= '0;
      end else begin
         rd_valid <= read_en;
         if (read_en) begin
            rd_entry_valid <= rd_hit;
            rd_div_zero    <= rd_src.div_zero;
            rd_opc         <= rd_src.opc;
            rd_op_a        <= rd_src.op_a;
            rd_op_b        <= rd_src.op_b;
            rd_rez         <= rd_src.rez;
         end
      end
   end

endmodule
